// File: rtl/handshake_responder.sv
// Four-phase bundled-data responder: synchronizes req_i, captures data_i once per
// handshake into a show-ahead FIFO. Optional watchdog via `HS_RESP_TIMEOUT_EN.
module handshake_responder #(
    parameter int DATA_W         = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          req_i,
    input  logic [DATA_W-1:0]             data_i,
    output logic                          ack_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_W-1:0]             out_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          timeout_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, ACKED} state_t;

    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    state_t                 state_q, state_d;
    logic                   ack_q;
    logic                   push, pop, full;

    logic [DATA_W-1:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic [DATA_W-1:0]      hold_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) req_sync <= '0;
        else          req_sync <= {req_sync[SYNC_STAGES-2:0], req_i};
    end
    assign req_s = req_sync[SYNC_STAGES-1];

    assign full = (count == CW'(FIFO_DEPTH));
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                // a full FIFO simply withholds ack; the initiator stalls
                if (req_s && !full) begin
                    push    = 1'b1;
                    state_d = ACKED;
                end
            end
            ACKED: begin
                if (!req_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_d == ACKED);
        end
    end
    assign ack_o = ack_q;

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // once drained, the output keeps the last word that was presented
    assign out_valid_o  = (count != '0);
    assign out_data_o   = out_valid_o ? mem[rd_ptr] : hold_q;
    assign fifo_count_o = count;

`ifdef HS_RESP_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TW-1:0] to_cnt;
    logic          to_flag;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (state_d == IDLE)
                to_cnt <= '0;
            else if (state_q == ACKED && req_s && to_cnt != TW'(TIMEOUT_CYCLES))
                to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TW'(TIMEOUT_CYCLES))
                to_flag <= 1'b1;
        end
    end
    assign timeout_o = to_flag;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
